// File: rtl/fetcher_pkg.sv
// -----------------------------------------------------------------------------
// fetcher_pkg
// Shared definitions for the multi-warp instruction fetcher:
//   fetcher_state_t : per-warp fetch FSM state with fixed encodings
//   DEF_*           : default parameter values
//   idx_width()     : width of an index into N items (at least 1 bit)
// -----------------------------------------------------------------------------
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAITING  = 2'b01,
        FETCHING = 2'b10,
        FETCHED  = 2'b11
    } fetcher_state_t;

    localparam int DEF_NUM_WARPS   = 4;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_INSTR_WIDTH = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_warp_fetcher_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first requester found
// when searching upward from ptr_i, wrapping modulo N.
// Ports:
//   req_i       [N-1:0]  request vector
//   ptr_i       [IW-1:0] search start index
//   grant_o     [N-1:0]  one-hot grant (all zero when no request)
//   grant_idx_o [IW-1:0] index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import fetcher_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_i) + 32'(i)) % 32'(N));
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/multi_warp_fetcher.sv
// -----------------------------------------------------------------------------
// multi_warp_fetcher
// Serves NUM_WARPS warps from one shared instruction-memory read port. Each
// warp owns a fetch FSM (IDLE/WAITING/FETCHING/FETCHED), a captured PC and an
// instruction holding register. A round-robin arbiter hands the port to one
// WAITING warp at a time; only one request is outstanding.
//
// Memory handshake: read_valid/read_address are raised on the grant edge and
// held stable until a cycle with read_ready=1; that cycle transfers the data.
// read_ready while read_valid=0 is ignored.
//
// Ports:
//   clk, reset (async, active low)
//   fetch_req/flush/consume [NUM_WARPS]     per-warp controls
//   pc [NUM_WARPS*ADDR_WIDTH]                warp w at [w*ADDR_WIDTH +: ADDR_WIDTH]
//   instruction_mem_read_valid/_address      request to memory
//   instruction_mem_read_ready/_data         response from memory
//   fetcher_state [NUM_WARPS*2]              per-warp FSM state
//   instruction [NUM_WARPS*INSTR_WIDTH]      per-warp held instruction
//   instruction_valid [NUM_WARPS]            warp is in FETCHED
// Optional (macro FETCHER_PERF_COUNTERS_EN):
//   perf_fetch_count [32], perf_stall_cycles [32]
// -----------------------------------------------------------------------------
module multi_warp_fetcher
    import fetcher_pkg::*;
#(
    parameter int NUM_WARPS   = DEF_NUM_WARPS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             fetch_req,
    input  logic [NUM_WARPS*ADDR_WIDTH-1:0]  pc,
    input  logic [NUM_WARPS-1:0]             flush,
    input  logic [NUM_WARPS-1:0]             consume,
    output logic                             instruction_mem_read_valid,
    output logic [ADDR_WIDTH-1:0]            instruction_mem_read_address,
    input  logic                             instruction_mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]           instruction_mem_read_data,
    output logic [NUM_WARPS*2-1:0]           fetcher_state,
    output logic [NUM_WARPS*INSTR_WIDTH-1:0] instruction,
    output logic [NUM_WARPS-1:0]             instruction_valid
`ifdef FETCHER_PERF_COUNTERS_EN
    ,
    output logic [31:0]                      perf_fetch_count,
    output logic [31:0]                      perf_stall_cycles
`endif
);

    localparam int IDXW = idx_width(NUM_WARPS);

    fetcher_state_t         state_q [NUM_WARPS];
    fetcher_state_t         state_d [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]  pc_q    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]  pc_d    [NUM_WARPS];
    logic [INSTR_WIDTH-1:0] instr_q [NUM_WARPS];
    logic [INSTR_WIDTH-1:0] instr_d [NUM_WARPS];

    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  bus_busy_q, bus_busy_d;
    logic [IDXW-1:0]       owner_q, owner_d;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  discard_q, discard_d;

    logic [NUM_WARPS-1:0]  req_vec;
    logic [NUM_WARPS-1:0]  grant_oh;
    logic [IDXW-1:0]       grant_idx;
    logic                  grant;
    logic                  complete;
    logic                  keep;

    // A warp being flushed this cycle must not be handed the bus.
    always_comb begin
        req_vec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            req_vec[w] = (state_q[w] == WAITING) && !flush[w];
        end
    end

    rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req_i       (req_vec),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx)
    );

    // bus_busy_q is still set in the cycle the transfer completes, so the
    // earliest next grant is naturally the following cycle.
    assign grant    = !bus_busy_q && (|grant_oh);
    assign complete = rd_valid_q && instruction_mem_read_ready;
    // Data is kept only if the owner was neither flushed earlier nor now.
    assign keep     = complete && !discard_q && !flush[owner_q];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        bus_busy_d = bus_busy_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        discard_d  = discard_q;

        if (complete) begin
            rd_valid_d = 1'b0;
            bus_busy_d = 1'b0;
            discard_d  = 1'b0;
            rr_ptr_d   = (owner_q == IDXW'(NUM_WARPS - 1)) ? '0 : owner_q + 1'b1;
        end

        if (grant) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = pc_q[grant_idx];
            bus_busy_d = 1'b1;
            owner_d    = grant_idx;
            discard_d  = 1'b0;
        end

        for (int w = 0; w < NUM_WARPS; w++) begin
            if (flush[w]) begin
                state_d[w] = IDLE;
                // Request stays on the bus; remember to drop its data.
                if (state_q[w] == FETCHING && !complete) begin
                    discard_d = 1'b1;
                end
            end else begin
                unique case (state_q[w])
                    IDLE: begin
                        if (fetch_req[w]) begin
                            state_d[w] = WAITING;
                            pc_d[w]    = pc[w*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                    end
                    WAITING: begin
                        if (grant && grant_oh[w]) begin
                            state_d[w] = FETCHING;
                        end
                    end
                    FETCHING: begin
                        if (keep && owner_q == IDXW'(w)) begin
                            state_d[w] = FETCHED;
                            instr_d[w] = instruction_mem_read_data;
                        end
                    end
                    FETCHED: begin
                        if (consume[w]) begin
                            if (fetch_req[w]) begin
                                state_d[w] = WAITING;
                                pc_d[w]    = pc[w*ADDR_WIDTH +: ADDR_WIDTH];
                            end else begin
                                state_d[w] = IDLE;
                            end
                        end
                    end
                    default: state_d[w] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                pc_q[w]    <= '0;
                instr_q[w] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            bus_busy_q <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            bus_busy_q <= bus_busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            discard_q  <= discard_d;
        end
    end

    assign instruction_mem_read_valid   = rd_valid_q;
    assign instruction_mem_read_address = rd_addr_q;

    always_comb begin
        fetcher_state     = '0;
        instruction       = '0;
        instruction_valid = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            fetcher_state[2*w +: 2]                 = state_q[w];
            instruction[w*INSTR_WIDTH +: INSTR_WIDTH] = instr_q[w];
            instruction_valid[w]                    = (state_q[w] == FETCHED);
        end
    end

`ifdef FETCHER_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        any_waiting;

    always_comb begin
        any_waiting = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (state_q[w] == WAITING) any_waiting = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (keep)                      perf_fetch_q <= perf_fetch_q + 32'd1;
            if (any_waiting && bus_busy_q) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_count  = perf_fetch_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_multi_warp_fetcher.sv
// -----------------------------------------------------------------------------
// tb_multi_warp_fetcher
// Bench for multi_warp_fetcher (NUM_WARPS=4, ADDR_WIDTH=12, INSTR_WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected read addresses are queued in exp_q in grant order and popped as
// the memory model answers each request.
// -----------------------------------------------------------------------------
module tb_multi_warp_fetcher;

    localparam int NW = 4;
    localparam int AW = 12;
    localparam int IW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NW-1:0]     fetch_req = '0;
    logic [NW*AW-1:0]  pc = '0;
    logic [NW-1:0]     flush = '0;
    logic [NW-1:0]     consume = '0;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic              mem_ready = 1'b0;
    logic [IW-1:0]     mem_data = '0;
    logic [NW*2-1:0]   fstate;
    logic [NW*IW-1:0]  instr;
    logic [NW-1:0]     ivalid;
`ifdef FETCHER_PERF_COUNTERS_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_stall;
`endif

    logic [AW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    multi_warp_fetcher #(.NUM_WARPS(NW), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk                          (clk),
        .reset                        (reset_n),
        .fetch_req                    (fetch_req),
        .pc                           (pc),
        .flush                        (flush),
        .consume                      (consume),
        .instruction_mem_read_valid   (mem_valid),
        .instruction_mem_read_address (mem_addr),
        .instruction_mem_read_ready   (mem_ready),
        .instruction_mem_read_data    (mem_data),
        .fetcher_state                (fstate),
        .instruction                  (instr),
        .instruction_valid            (ivalid)
`ifdef FETCHER_PERF_COUNTERS_EN
        ,
        .perf_fetch_count             (perf_fetch),
        .perf_stall_cycles            (perf_stall)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [1:0] st(input int w);
        return fstate[2*w +: 2];
    endfunction

    function automatic logic [IW-1:0] ins(input int w);
        return instr[w*IW +: IW];
    endfunction

    function automatic logic [IW-1:0] mk_data(input logic [AW-1:0] a);
        return {20'hA5A5A, a};
    endfunction

    task automatic set_pc(input int w, input logic [AW-1:0] v);
        pc[w*AW +: AW] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        fetch_req = '0;
        flush     = '0;
        consume   = '0;
        mem_ready = 1'b0;
        pc        = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Memory model: answers n requests, stalling `stall` cycles on each.
    // With always_rdy, ready is also held high while no request is pending.
    task automatic serve(input int n, input int stall, input bit always_rdy);
        int served;
        int waited;
        int cyc;
        served    = 0;
        waited    = 0;
        cyc       = 0;
        mem_ready = always_rdy;
        while (served < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL serve_addr: got %h, no request expected", mem_addr);
                end else if (mem_addr !== exp_q[0]) begin
                    n_mis++;
                    $display("FAIL serve_addr: got %h, expected %h", mem_addr, exp_q[0]);
                end
                if (waited < stall) begin
                    mem_ready = 1'b0;
                    waited++;
                end else begin
                    mem_ready = 1'b1;
                    mem_data  = (exp_q.size() != 0) ? mk_data(exp_q[0]) : 32'hBAD0BAD0;
                    if (exp_q.size() != 0) exp_q.delete(0);
                    served++;
                    waited = 0;
                end
            end else begin
                mem_ready = always_rdy;
                mem_data  = 32'hBAD0BAD0;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_cmp++;
        if (served != n) begin
            n_mis++;
            $display("FAIL serve_timeout: served %0d, expected %0d", served, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b, expected 0", mem_valid); end
        n_cmp++; if (mem_addr !== '0) begin n_mis++; $display("FAIL reset_addr: got %h, expected 0", mem_addr); end
        n_cmp++; if (fstate !== '0) begin n_mis++; $display("FAIL reset_state: got %h, expected 0", fstate); end
        n_cmp++; if (instr !== '0) begin n_mis++; $display("FAIL reset_instr: got %h, expected 0", instr); end
        n_cmp++; if (ivalid !== '0) begin n_mis++; $display("FAIL reset_ivalid: got %b, expected 0", ivalid); end
`ifdef FETCHER_PERF_COUNTERS_EN
        n_cmp++; if (perf_fetch !== 32'd0 || perf_stall !== 32'd0) begin n_mis++; $display("FAIL reset_perf: got %0d/%0d, expected 0/0", perf_fetch, perf_stall); end
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (fstate !== '0 || mem_valid !== 1'b0) begin n_mis++; $display("FAIL reset_idle: state %h valid %b, expected 0/0", fstate, mem_valid); end
    endtask

    task automatic test_single();
        do_reset();
        fetch_req[0] = 1'b1;
        set_pc(0, 12'h010);
        @(negedge clk);
        fetch_req = '0;
        n_cmp++; if (st(0) !== 2'b01) begin n_mis++; $display("FAIL single_waiting: got %b, expected 01", st(0)); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_mis++; $display("FAIL single_early_valid: got %b, expected 0", mem_valid); end
        @(negedge clk);
        n_cmp++; if (mem_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid: got %b, expected 1", mem_valid); end
        n_cmp++; if (mem_addr !== 12'h010) begin n_mis++; $display("FAIL single_addr: got %h, expected 010", mem_addr); end
        n_cmp++; if (st(0) !== 2'b10) begin n_mis++; $display("FAIL single_fetching: got %b, expected 10", st(0)); end
        mem_ready = 1'b1;
        mem_data  = 32'hDEADBEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        n_cmp++; if (ivalid[0] !== 1'b1) begin n_mis++; $display("FAIL single_ivalid: got %b, expected 1", ivalid[0]); end
        n_cmp++; if (ins(0) !== 32'hDEADBEEF) begin n_mis++; $display("FAIL single_instr: got %h, expected deadbeef", ins(0)); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_mis++; $display("FAIL single_valid_drop: got %b, expected 0", mem_valid); end
        consume[0] = 1'b1;
        @(negedge clk);
        consume = '0;
        n_cmp++; if (st(0) !== 2'b00 || ivalid[0] !== 1'b0) begin n_mis++; $display("FAIL single_consume: state %b ivalid %b, expected 00/0", st(0), ivalid[0]); end
        n_cmp++; if (ins(0) !== 32'hDEADBEEF) begin n_mis++; $display("FAIL single_hold: got %h, expected deadbeef", ins(0)); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a;
        do_reset();
        for (int w = 0; w < NW; w++) begin
            a = 12'h100 + AW'(16 * w);
            set_pc(w, a);
            exp_q.push_back(a);
        end
        fetch_req = '1;
        @(negedge clk);
        fetch_req = '0;
        serve(4, 0, 1'b1);
        for (int w = 0; w < NW; w++) begin
            a = 12'h100 + AW'(16 * w);
            n_cmp++; if (st(w) !== 2'b11 || ins(w) !== mk_data(a)) begin n_mis++; $display("FAIL rr_instr w%0d: state %b instr %h, expected 11/%h", w, st(w), ins(w), mk_data(a)); end
        end
        // Second round: leave rr_ptr at 1, then warps 0 and 1 wait together.
        consume = '1;
        @(negedge clk);
        consume = '0;
        set_pc(0, 12'h140);
        exp_q.push_back(12'h140);
        fetch_req[0] = 1'b1;
        @(negedge clk);
        fetch_req = '0;
        serve(1, 0, 1'b0);
        consume[0]   = 1'b1;
        fetch_req[0] = 1'b1;
        fetch_req[1] = 1'b1;
        set_pc(0, 12'h150);
        set_pc(1, 12'h160);
        exp_q.push_back(12'h160);
        exp_q.push_back(12'h150);
        @(negedge clk);
        consume   = '0;
        fetch_req = '0;
        serve(2, 0, 1'b1);
        n_cmp++; if (ins(1) !== mk_data(12'h160)) begin n_mis++; $display("FAIL rr2_w1: got %h, expected %h", ins(1), mk_data(12'h160)); end
        n_cmp++; if (ins(0) !== mk_data(12'h150)) begin n_mis++; $display("FAIL rr2_w0: got %h, expected %h", ins(0), mk_data(12'h150)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] stall0;
        stall0 = '0;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            set_pc(w, 12'h200 + AW'(16 * w));
            exp_q.push_back(12'h200 + AW'(16 * w));
        end
        fetch_req = 4'b0111;
        @(negedge clk);
        fetch_req = '0;
        @(negedge clk);
`ifdef FETCHER_PERF_COUNTERS_EN
        stall0 = perf_stall;
`endif
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 12'h200) begin n_mis++; $display("FAIL bp_hold c%0d: valid %b addr %h, expected 1/200", k, mem_valid, mem_addr); end
            n_cmp++; if (st(1) !== 2'b01 || st(2) !== 2'b01) begin n_mis++; $display("FAIL bp_waiting c%0d: w1 %b w2 %b, expected 01/01", k, st(1), st(2)); end
            @(negedge clk);
        end
`ifdef FETCHER_PERF_COUNTERS_EN
        n_cmp++; if (perf_stall - stall0 !== 32'd5) begin n_mis++; $display("FAIL bp_perf_stall: got delta %0d, expected 5", perf_stall - stall0); end
`endif
        serve(3, 0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            n_cmp++; if (ins(w) !== mk_data(12'h200 + AW'(16 * w))) begin n_mis++; $display("FAIL bp_instr w%0d: got %h, expected %h", w, ins(w), mk_data(12'h200 + AW'(16 * w))); end
        end
`ifdef FETCHER_PERF_COUNTERS_EN
        n_cmp++; if (perf_fetch !== 32'd3) begin n_mis++; $display("FAIL bp_perf_fetch: got %0d, expected 3", perf_fetch); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        set_pc(2, 12'h300);
        set_pc(3, 12'h310);
        fetch_req = 4'b1100;
        @(negedge clk);
        fetch_req = '0;
        @(negedge clk);
        n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 12'h300 || st(2) !== 2'b10) begin n_mis++; $display("FAIL flush_pre: valid %b addr %h w2 %b, expected 1/300/10", mem_valid, mem_addr, st(2)); end
        flush[2] = 1'b1;
        @(negedge clk);
        flush = '0;
        n_cmp++; if (st(2) !== 2'b00 || ivalid[2] !== 1'b0) begin n_mis++; $display("FAIL flush_idle: w2 %b ivalid %b, expected 00/0", st(2), ivalid[2]); end
        n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 12'h300) begin n_mis++; $display("FAIL flush_hold: valid %b addr %h, expected 1/300", mem_valid, mem_addr); end
        mem_ready = 1'b1;
        mem_data  = 32'h12345678;
        @(negedge clk);
        mem_ready = 1'b0;
        n_cmp++; if (mem_valid !== 1'b0 || st(3) !== 2'b01) begin n_mis++; $display("FAIL flush_free: valid %b w3 %b, expected 0/01", mem_valid, st(3)); end
        @(negedge clk);
        n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 12'h310) begin n_mis++; $display("FAIL flush_next_grant: valid %b addr %h, expected 1/310", mem_valid, mem_addr); end
        n_cmp++; if (ins(2) !== '0 || st(2) !== 2'b00) begin n_mis++; $display("FAIL flush_discard: w2 instr %h state %b, expected 0/00", ins(2), st(2)); end
        exp_q.push_back(12'h310);
        serve(1, 0, 1'b0);
        n_cmp++; if (ins(3) !== mk_data(12'h310) || ivalid[3] !== 1'b1) begin n_mis++; $display("FAIL flush_w3: instr %h ivalid %b, expected %h/1", ins(3), ivalid[3], mk_data(12'h310)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_pc(3, 12'h030);
        exp_q.push_back(12'h030);
        fetch_req[3] = 1'b1;
        @(negedge clk);
        fetch_req = '0;
        serve(1, 0, 1'b0);
        n_cmp++; if (st(3) !== 2'b11) begin n_mis++; $display("FAIL b2b_fetched: got %b, expected 11", st(3)); end
        consume[3]   = 1'b1;
        fetch_req[3] = 1'b1;
        set_pc(3, 12'h020);
        @(negedge clk);
        consume   = '0;
        fetch_req = '0;
        n_cmp++; if (st(3) !== 2'b01 || ivalid[3] !== 1'b0) begin n_mis++; $display("FAIL b2b_waiting: state %b ivalid %b, expected 01/0", st(3), ivalid[3]); end
        n_cmp++; if (ins(3) !== mk_data(12'h030)) begin n_mis++; $display("FAIL b2b_hold: got %h, expected %h", ins(3), mk_data(12'h030)); end
        exp_q.push_back(12'h020);
        serve(1, 0, 1'b0);
        n_cmp++; if (ins(3) !== mk_data(12'h020) || st(3) !== 2'b11) begin n_mis++; $display("FAIL b2b_instr: instr %h state %b, expected %h/11", ins(3), st(3), mk_data(12'h020)); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_pc(1, 12'h040);
        exp_q.push_back(12'h040);
        fetch_req[1] = 1'b1;
        @(negedge clk);
        fetch_req = '0;
        serve(1, 0, 1'b0);
        set_pc(0, 12'h050);
        fetch_req[0] = 1'b1;
        @(negedge clk);
        fetch_req = '0;
        @(negedge clk);
        n_cmp++; if (mem_valid !== 1'b1 || st(0) !== 2'b10) begin n_mis++; $display("FAIL areset_pre: valid %b w0 %b, expected 1/10", mem_valid, st(0)); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_valid !== 1'b0 || mem_addr !== '0) begin n_mis++; $display("FAIL areset_bus: valid %b addr %h, expected 0/0", mem_valid, mem_addr); end
        n_cmp++; if (fstate !== '0 || ivalid !== '0 || instr !== '0) begin n_mis++; $display("FAIL areset_outputs: state %h ivalid %b instr %h, expected 0", fstate, ivalid, instr); end
        mem_ready = 1'b1;
        mem_data  = 32'hDEADDEAD;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (instr !== '0 || fstate !== '0 || mem_valid !== 1'b0) begin n_mis++; $display("FAIL areset_stale c%0d: instr %h state %h valid %b, expected 0", k, instr, fstate, mem_valid); end
        end
        mem_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/multi_warp_fetcher.md
Name: multi_warp_fetcher

Overview:
Parametrised successor to the single-warp fetcher. It serves NUM_WARPS warps from one shared instruction-memory read port. Each warp has its own fetch FSM, its own captured PC and its own instruction holding register. A round-robin arbiter grants the port, with one outstanding request at a time. The block sits between the per-warp scheduler/PC logic and the decoder inside a compute core.

Parameters:
NUM_WARPS, 4, number of warps served (>=1)
ADDR_WIDTH, 12, instruction memory address width
INSTR_WIDTH, 32, instruction word width

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
fetch_req  input  NUM_WARPS  per-warp fetch request, level, sampled in IDLE/FETCHED
pc  input  NUM_WARPS*ADDR_WIDTH  per-warp PC; warp w occupies bits [w*ADDR_WIDTH +: ADDR_WIDTH]
flush  input  NUM_WARPS  per-warp cancel
consume  input  NUM_WARPS  decoder has taken the held instruction
instruction_mem_read_valid  output  1  read request valid
instruction_mem_read_address  output  ADDR_WIDTH  read address
instruction_mem_read_ready  input  1  memory returns data this cycle
instruction_mem_read_data  input  INSTR_WIDTH  returned instruction
fetcher_state  output  NUM_WARPS*2  per-warp FSM state
instruction  output  NUM_WARPS*INSTR_WIDTH  per-warp held instruction
instruction_valid  output  NUM_WARPS  high when the warp is in FETCHED

Behaviour:
- Reset (reset=0, asynchronous): every warp goes to IDLE; instruction=0; instruction_valid=0; read_valid=0; read_address=0; bus_busy=0; rr_ptr=0; any discard flag cleared. All outputs are registered.
- Per-warp FSM, encoding IDLE=2'b00, WAITING=2'b01, FETCHING=2'b10, FETCHED=2'b11:
  - IDLE: fetch_req=1 -> capture pc, go to WAITING.
  - WAITING: if granted (bus_busy=0) -> go to FETCHING; set read_valid=1 and read_address=captured pc on the same edge.
  - FETCHING: read_valid=1 and read_ready=1 -> latch read_data into instruction, go to FETCHED, clear bus_busy, set rr_ptr=(owner+1) mod NUM_WARPS.
  - FETCHED: consume=1 with fetch_req=0 -> IDLE. consume=1 with fetch_req=1 -> WAITING with the new pc (back-to-back). The instruction register holds its value until the next fetch completes.
  - fetch_req is ignored in WAITING and FETCHING.
- Arbitration:
  - Evaluated combinationally only when bus_busy=0.
  - Grants the first warp in WAITING, searching from rr_ptr upward and wrapping modulo NUM_WARPS.
  - No grant is made in the cycle the bus frees; the earliest new grant is the following cycle.
- Memory handshake:
  - read_valid and read_address are held stable until read_ready is seen high.
  - read_ready while read_valid=0 is ignored.
- Minimum latency: fetch_req in cycle 0 -> WAITING in cycle 1 -> read_valid high in cycle 2 -> with ready in cycle 2, instruction_valid is high in cycle 3.
- Flush (priority over fetch_req and consume):
  - The warp goes to IDLE next edge; instruction_valid drops.
  - If the warp owns the bus, read_valid stays high until ready. The returned data is discarded via a discard flag, and the instruction register is not written.
- Simultaneous events:
  - Several warps enter WAITING in the same cycle: resolved by round-robin.
  - Flush on the owner in the same cycle as ready: data is discarded and the bus is freed normally.
- Reset mid-transfer drops the request immediately. Memory must tolerate an abandoned request.

Optional Feature:
FETCHER_PERF_COUNTERS_EN: adds two outputs, perf_fetch_count[31:0] and perf_stall_cycles[31:0]. Both clear on reset and wrap at 2^32.
- perf_fetch_count increments per completed non-discarded fetch.
- perf_stall_cycles increments each cycle where some warp is WAITING and bus_busy=1.
Without the macro, both ports and all counter logic are absent.

Decomposition:
- Shared package fetcher_pkg holds: fetcher_state_t enum (IDLE/WAITING/FETCHING/FETCHED with fixed encodings) and default width localparams.
- Sub-module rr_arbiter #(N): request vector plus pointer in, one-hot grant and grant index out; purely combinational.

Test Plan:
- Single warp: NUM_WARPS=4, warp0 fetch_req with pc=0x010 at cycle 0, ready in cycle 2 with data 0xDEADBEEF -> read_address=0x010 in cycle 2; instruction[31:0]=0xDEADBEEF and instruction_valid[0]=1 in cycle 3.
- Round-robin: all four warps request in the same cycle, ready always 1 -> grant order 0,1,2,3. A second round starting with warp1 pending at rr_ptr=1 grants warp1 first.
- Backpressure: ready held low for 5 cycles -> read_valid and address stable for all 5 cycles; other warps stay WAITING; perf_stall_cycles (if enabled) increments.
- Flush in flight: flush warp2 while it is FETCHING -> warp2 goes to IDLE next cycle; returned data 0x12345678 is not latched; the next WAITING warp is granted the cycle after ready.
- Back-to-back: warp3 in FETCHED with consume=1, fetch_req=1, pc=0x020 -> WAITING next cycle; the following request address is 0x020.
- Async reset asserted mid-FETCHING -> all outputs zero immediately (before the next clk edge); after release, no stale response is latched.
